// File: rtl/regfile_master.sv
// -----------------------------------------------------------------------------
// regfile_master
//
// Turns single word commands (read or byte-masked write) into accesses on a
// BRAM-style initiator port toward a register-file responder. Only one
// command is in flight at a time. The response is held until it is consumed.
//
// Handshake rule for both channels:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer keeps valid and its payload stable until that transfer.
//   cmd_ready depends only on the FSM state and rst. rsp_valid depends only
//   on the FSM state.
//
// Optional feature: define REGFILE_MASTER_WRITE_VERIFY_EN to read back every
// write that has a nonzero byte enable. The readback goes to rsp_rdata.
// rsp_err flags any enabled byte that differs from the written data.
// When the macro is undefined, rsp_err is tied 0.
//
// Parameters
//   Naddr   word-index width (2**Naddr 32-bit registers, Naddr <= 10)
//   RD_LAT  responder read latency in clocks (1..3)
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_idx               register word index
//   cmd_wdata, cmd_be     write data and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data (writes: 0, or readback with verify)
//   rsp_err               write-verify mismatch
//   regfile_addr          byte address {idx, 2'b00}
//   regfile_en            single-cycle access strobe
//   regfile_we            byte write enables (0 whenever regfile_en is 0)
//   regfile_din           write data toward the responder
//   regfile_dout          read data from the responder, RD_LAT clocks after en
//   dbg_state             current FSM state, for observation
// -----------------------------------------------------------------------------
module regfile_master #(
    parameter int Naddr  = 6,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [Naddr-1:0] cmd_idx,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [11:0]      regfile_addr,
    output logic             regfile_en,
    output logic [3:0]       regfile_we,
    output logic [31:0]      regfile_din,
    input  logic [31:0]      regfile_dout,
    output logic [2:0]       dbg_state
);

    // The wait counter only ever counts 0 .. RD_LAT-1.
    localparam int            CW       = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
        ,
        S_VRD    = 3'd4,
        S_VWAIT  = 3'd5
`endif
    } state_t;

    state_t            state;
    state_t            next_state;

    // The command is captured at acceptance. cmd_* is ignored after that.
    logic [Naddr-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              write_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              wait_done;

    assign accept    = cmd_valid && cmd_ready;
    assign wait_done = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    // A write with no enabled bytes has nothing to do on the
                    // port, so it answers immediately.
                    if (cmd_write && (cmd_be == 4'h0)) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (write_q) begin
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
                    next_state = S_VRD;
`else
                    next_state = S_RESP;
`endif
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    next_state = S_RESP;
                end
            end
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
            S_VRD: begin
                next_state = S_VWAIT;
            end
            S_VWAIT: begin
                if (wait_done) begin
                    next_state = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // The regfile_* outputs depend only on registered state, so no
    // combinational path runs from cmd_* or rsp_ready to the port.
    // -------------------------------------------------------------------------
    always_comb begin
        regfile_en  = 1'b0;
        regfile_we  = 4'h0;
        regfile_din = 32'h0;
        case (state)
            S_ACCESS: begin
                regfile_en = 1'b1;
                if (write_q) begin
                    regfile_we  = be_q;
                    regfile_din = wdata_q;
                end
            end
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
            S_VRD: begin
                regfile_en = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        regfile_addr = 12'({idx_q, 2'b00});
        rsp_valid    = (state == S_RESP);
        cmd_ready    = (state == S_IDLE) && !rst;
        dbg_state    = state;
    end

    // -------------------------------------------------------------------------
    // Command capture, wait counter, response data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                idx_q   <= cmd_idx;
                wdata_q <= cmd_wdata;
                be_q    <= cmd_be;
                write_q <= cmd_write;
                rdata_q <= 32'h0;
            end

            // The counter runs only in the wait states. It is zero on every
            // wait-state entry, so its final wrap is never seen.
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
            if ((state == S_WAIT) || (state == S_VWAIT)) begin
`else
            if (state == S_WAIT) begin
`endif
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end

            // The last wait cycle is the one in which responder data is valid.
            if ((state == S_WAIT) && wait_done) begin
                rdata_q <= regfile_dout;
            end
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
            if ((state == S_VWAIT) && wait_done) begin
                rdata_q <= regfile_dout;
            end
`endif
        end
    end

`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
    // Only bytes that the write enabled take part in the comparison.
    logic        err_q;
    logic [31:0] be_mask;

    assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == S_VWAIT) && wait_done) begin
            err_q <= |((regfile_dout ^ wdata_q) & be_mask);
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_master.sv
module tb_regfile_master;

`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1: RD_LAT = 1, byte-addressable memory responder
  logic        rst;
  logic        c_valid, c_ready, c_write;
  logic [5:0]  c_idx;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic        r_valid, r_ready, r_err;
  logic [31:0] r_rdata;
  logic [11:0] rf_addr;
  logic        rf_en;
  logic [3:0]  rf_we;
  logic [31:0] rf_din, rf_dout;
  logic [2:0]  dbg1;

  // dut3: RD_LAT = 3, address-echo responder
  logic        rst3;
  logic        c3_valid, c3_ready, c3_write;
  logic [5:0]  c3_idx;
  logic [31:0] c3_wdata;
  logic [3:0]  c3_be;
  logic        r3_valid, r3_ready, r3_err;
  logic [31:0] r3_rdata;
  logic [11:0] rf3_addr;
  logic        rf3_en;
  logic [3:0]  rf3_we;
  logic [31:0] rf3_din, rf3_dout;
  logic [2:0]  dbg3;

  regfile_master #(.Naddr(6), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_write(c_write),
    .cmd_idx(c_idx), .cmd_wdata(c_wdata), .cmd_be(c_be),
    .rsp_valid(r_valid), .rsp_ready(r_ready), .rsp_rdata(r_rdata), .rsp_err(r_err),
    .regfile_addr(rf_addr), .regfile_en(rf_en), .regfile_we(rf_we),
    .regfile_din(rf_din), .regfile_dout(rf_dout), .dbg_state(dbg1)
  );

  regfile_master #(.Naddr(6), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
    .cmd_idx(c3_idx), .cmd_wdata(c3_wdata), .cmd_be(c3_be),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_rdata(r3_rdata), .rsp_err(r3_err),
    .regfile_addr(rf3_addr), .regfile_en(rf3_en), .regfile_we(rf3_we),
    .regfile_din(rf3_din), .regfile_dout(rf3_dout), .dbg_state(dbg3)
  );

  // ---------------------------------------------------------------------------
  // Responders
  // ---------------------------------------------------------------------------
  // dut1 responder: 64-word memory with 1-cycle read latency. Bit 0 of word 4
  // reads back stuck at 0. Outside a read, dout carries a junk pattern, so
  // data sampled in the wrong cycle shows up as wrong.
  logic [31:0] mem [64];

  function automatic logic [31:0] rd_word(input logic [5:0] i);
    logic [31:0] v;
    v = mem[i];
    if (i == 6'd4) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (rf_en && (rf_we != 4'h0)) begin
      for (int b = 0; b < 4; b++)
        if (rf_we[b]) mem[rf_addr[7:2]][b*8 +: 8] <= rf_din[b*8 +: 8];
    end
    if (rf_en && (rf_we == 4'h0)) rf_dout <= rd_word(rf_addr[7:2]);
    else rf_dout <= 32'hBAD0_BAD0;
  end

  // dut3 responder: a 3-stage pipeline that returns {20'hABCDE, addr} for a
  // read, and 0 in every other slot.
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= (rf3_en && (rf3_we == 4'h0)) ? {20'hABCDE, rf3_addr} : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rf3_dout = p3[2];

  // Port monitor for dut1: counts en pulses and any we activity without en.
  int en_pulses = 0;
  int we_bad = 0;
  always @(negedge clk) begin
    if (rf_en) en_pulses++;
    if (!rf_en && (rf_we != 4'h0)) we_bad++;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / checking
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver for dut1: runs one command to completion.
  // hold is the number of RESP cycles with rsp_ready=0 before consumption.
  // ---------------------------------------------------------------------------
  task automatic run_cmd(input string tag, input logic wr, input logic [5:0] idx,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic exp_err, input int hold);
    int exp_lat, exp_pulses, p0, n;
    logic [31:0] exp_rdata;
    exp_rdata = exp_q.pop_front();
    if (!wr) begin
      exp_lat = 3; exp_pulses = 1;
    end else if (be == 4'h0) begin
      exp_lat = 1; exp_pulses = 0;
    end else if (VERIFY) begin
      exp_lat = 4; exp_pulses = 2;
    end else begin
      exp_lat = 2; exp_pulses = 1;
    end
    r_ready = (hold == 0);
    check({tag, ":cmd_ready"}, 32'(c_ready), 32'd1);
    p0 = en_pulses;
    c_valid = 1'b1; c_write = wr; c_idx = idx; c_wdata = wd; c_be = be;
    tick;
    // Cycle T+1. Scramble the command bus; it must have no effect now.
    c_valid = 1'b0;
    c_write = 1'($urandom_range(0, 1));
    c_idx   = 6'($urandom_range(0, 63));
    c_wdata = $urandom;
    c_be    = 4'($urandom_range(0, 15));
    if (exp_pulses > 0) begin
      check({tag, ":en"}, 32'(rf_en), 32'd1);
      check({tag, ":addr"}, 32'(rf_addr), 32'({idx, 2'b00}));
      check({tag, ":we"}, 32'(rf_we), 32'(wr ? be : 4'h0));
      if (wr) check({tag, ":din"}, rf_din, wd);
    end else begin
      check({tag, ":no_en"}, 32'(rf_en), 32'd0);
    end
    n = 1;
`ifdef REGFILE_MASTER_WRITE_VERIFY_EN
    if (wr && (be != 4'h0)) begin
      tick;
      n = 2;
      check({tag, ":vrd_en"}, 32'(rf_en), 32'd1);
      check({tag, ":vrd_we"}, 32'(rf_we), 32'd0);
      check({tag, ":vrd_addr"}, 32'(rf_addr), 32'({idx, 2'b00}));
    end
`endif
    while (!r_valid && (n < 20)) begin
      tick;
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(exp_lat));
    check({tag, ":rdata"}, r_rdata, exp_rdata);
    check({tag, ":err"}, 32'(r_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      check({tag, ":hold_valid"}, 32'(r_valid), 32'd1);
      check({tag, ":hold_rdata"}, r_rdata, exp_rdata);
      check({tag, ":hold_ready"}, 32'(c_ready), 32'd0);
      tick;
    end
    r_ready = 1'b1;
    if (hold > 0) check({tag, ":last_valid"}, 32'(r_valid), 32'd1);
    tick;
    check({tag, ":pulses"}, 32'(en_pulses - p0), 32'(exp_pulses));
    check({tag, ":done_valid"}, 32'(r_valid), 32'd0);
    check({tag, ":done_ready"}, 32'(c_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int evt;
    rst = 1'b1; c_valid = 1'b0; c_write = 1'b0; c_idx = '0; c_wdata = '0; c_be = '0;
    r_ready = 1'b1;
    rst3 = 1'b1; c3_valid = 1'b0; c3_write = 1'b0; c3_idx = '0; c3_wdata = '0; c3_be = '0;
    r3_ready = 1'b1;
    repeat (3) tick;

    // Reset state
    check("rst:cmd_ready", 32'(c_ready), 32'd0);
    check("rst:rsp_valid", 32'(r_valid), 32'd0);
    check("rst:rsp_rdata", r_rdata, 32'h0);
    check("rst:rsp_err", 32'(r_err), 32'd0);
    check("rst:en", 32'(rf_en), 32'd0);
    check("rst:we", 32'(rf_we), 32'd0);
    check("rst:addr", 32'(rf_addr), 32'd0);
    check("rst:din", rf_din, 32'h0);
    rst = 1'b0; rst3 = 1'b0;
    #1;
    check("rst:ready_after", 32'(c_ready), 32'd1);

    // Expected rsp_rdata values for each command, in order.
    exp_q.push_back(VERIFY ? 32'h0000_00A5 : 32'h0);   // wr2
    exp_q.push_back(32'h0000_00A5);                    // rd2
    exp_q.push_back(VERIFY ? 32'hCCCC_CCCC : 32'h0);   // wr3 fill
    exp_q.push_back(VERIFY ? 32'hCCCC_3344 : 32'h0);   // wr3 be=3
    exp_q.push_back(32'hCCCC_3344);                    // rd3
    exp_q.push_back(32'h0000_00A5);                    // rd2 stalled
    exp_q.push_back(32'h0);                            // wr5 be=0
    exp_q.push_back(32'h0);                            // rd5
    exp_q.push_back(VERIFY ? 32'hDEAD_BEEF : 32'h0);   // wr63
    exp_q.push_back(32'hDEAD_BEEF);                    // rd63
    exp_q.push_back(VERIFY ? 32'hFFFF_FFFE : 32'h0);   // wr4 stuck bit
    exp_q.push_back(32'hFFFF_FFFE);                    // rd4

    run_cmd("wr2",    1'b1, 6'd2,  32'h0000_00A5, 4'hF, 1'b0, 0);
    run_cmd("rd2",    1'b0, 6'd2,  32'h0,         4'h0, 1'b0, 0);
    run_cmd("wr3f",   1'b1, 6'd3,  32'hCCCC_CCCC, 4'hF, 1'b0, 0);
    run_cmd("wr3be",  1'b1, 6'd3,  32'h1122_3344, 4'h3, 1'b0, 0);
    run_cmd("rd3",    1'b0, 6'd3,  32'h0,         4'h0, 1'b0, 0);
    run_cmd("rd2st",  1'b0, 6'd2,  32'h0,         4'h0, 1'b0, 5);
    run_cmd("wr5be0", 1'b1, 6'd5,  32'h1234_5678, 4'h0, 1'b0, 0);
    run_cmd("rd5",    1'b0, 6'd5,  32'h0,         4'h0, 1'b0, 0);
    run_cmd("wr63",   1'b1, 6'd63, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
    run_cmd("rd63",   1'b0, 6'd63, 32'h0,         4'h0, 1'b0, 0);
    run_cmd("wr4",    1'b1, 6'd4,  32'hFFFF_FFFF, 4'hF, VERIFY, 0);
    run_cmd("rd4",    1'b0, 6'd4,  32'h0,         4'h0, 1'b0, 0);
    check("we_without_en", 32'(we_bad), 32'd0);

    // dut3: a full read with RD_LAT = 3 (response at T+5)
    check("l3:cmd_ready", 32'(c3_ready), 32'd1);
    c3_valid = 1'b1; c3_write = 1'b0; c3_idx = 6'd7;
    tick;
    c3_valid = 1'b0; c3_idx = 6'd0;
    check("l3:en", 32'(rf3_en), 32'd1);
    check("l3:addr", 32'(rf3_addr), 32'h01C);
    n = 1;
    while (!r3_valid && (n < 20)) begin
      tick;
      n++;
    end
    check("l3:latency", 32'(n), 32'd5);
    check("l3:rdata", r3_rdata, 32'hABCD_E01C);
    tick;
    check("l3:done_ready", 32'(c3_ready), 32'd1);

    // dut3: reset while waiting for read data aborts the read
    c3_valid = 1'b1; c3_write = 1'b0; c3_idx = 6'd9;
    tick;                       // T+1: ACCESS
    c3_valid = 1'b0;
    tick;                       // T+2: first wait cycle
    check("ab:wait_en", 32'(rf3_en), 32'd0);
    check("ab:wait_valid", 32'(r3_valid), 32'd0);
    rst3 = 1'b1;
    tick;
    check("ab:cmd_ready", 32'(c3_ready), 32'd0);
    check("ab:rsp_valid", 32'(r3_valid), 32'd0);
    check("ab:rsp_rdata", r3_rdata, 32'h0);
    check("ab:rsp_err", 32'(r3_err), 32'd0);
    check("ab:en", 32'(rf3_en), 32'd0);
    check("ab:we", 32'(rf3_we), 32'd0);
    check("ab:addr", 32'(rf3_addr), 32'd0);
    check("ab:din", rf3_din, 32'h0);
    rst3 = 1'b0;
    #1;
    check("ab:ready_after", 32'(c3_ready), 32'd1);
    evt = 0;
    repeat (8) begin
      tick;
      if (rf3_en || r3_valid) evt++;
    end
    check("ab:no_activity", 32'(evt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time limit: the run must finish on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 SHALL have parameter Naddr, default 6, meaning word-index width (2**Naddr 32-bit registers).
REQ-002 SHALL have parameter RD_LAT, default 1, meaning responder read latency in clocks (legal 1..3).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_idx  input  Naddr  register word index.
REQ-009 SHALL have port cmd_wdata  input  32  write data.
REQ-010 SHALL have port cmd_be  input  4  write byte enables.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-013 SHALL have port rsp_rdata  output  32  read data (writes: 0, or readback under REQ-031).
REQ-014 SHALL have port rsp_err  output  1  write-verify mismatch flag.
REQ-015 SHALL have ports regfile_addr output 12 byte address, regfile_en output 1, regfile_we output 4, regfile_din output 32, regfile_dout input 32: BRAM-style initiator port toward a register-file responder.

Function
REQ-016 SHALL use FSM states IDLE, ACCESS, WAIT, RESP (plus VRD, VWAIT under REQ-031).
REQ-017 SHALL assert cmd_ready only in IDLE; accept at most one outstanding command.
REQ-018 SHALL drive regfile_addr = {zeros, idx, 2'b00}; idx captured at acceptance and held until RESP exits.
REQ-019 Read accepted in cycle T: SHALL assert regfile_en=1, regfile_we=0 in cycle T+1 only; SHALL register regfile_dout at end of cycle T+1+RD_LAT; rsp_valid=1 from cycle T+2+RD_LAT.
REQ-020 Write accepted in cycle T with cmd_be!=0: SHALL assert regfile_en=1, regfile_we=cmd_be, regfile_din=cmd_wdata in cycle T+1 only; rsp_valid=1 from cycle T+2, rsp_rdata=0.
REQ-021 Write with cmd_be=0: SHALL issue no regfile_en pulse; rsp_valid=1 from cycle T+1, rsp_rdata=0, rsp_err=0.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid&rsp_ready; then return to IDLE next cycle (cmd_ready=1).
REQ-023 SHALL keep regfile_we=0 whenever regfile_en=0; regfile_en SHALL be a single-cycle pulse per access.
REQ-024 SHALL count WAIT cycles with a counter of width ceil(log2(RD_LAT+1)), wrapping never observable (cleared on ACCESS entry).
REQ-025 cmd_* inputs ignored outside IDLE; changes after acceptance SHALL not affect the transaction.
REQ-026 SHALL expose no combinational path from cmd_* or rsp_ready to regfile_* outputs.

Reset
REQ-027 While rst=1 at a clock edge: FSM=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, regfile_en=0, regfile_we=0, regfile_addr=0, regfile_din=0.
REQ-028 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-transaction SHALL abort it: no further regfile_en pulse, pending response discarded.

Configuration
REQ-030 Macro REGFILE_MASTER_WRITE_VERIFY_EN SHALL select write-verify.
REQ-031 Defined: after a write's ACCESS, SHALL issue a read to the same address in the next cycle (VRD), wait RD_LAT (VWAIT), set rsp_rdata=readback, rsp_err=1 iff (readback^wdata) masked by cmd_be per byte !=0; write rsp_valid from cycle T+3+RD_LAT. be=0 writes unaffected.
REQ-032 Undefined: no VRD/VWAIT states; rsp_err tied 0; write timing per REQ-020.

Verification
REQ-033 RD_LAT=1, write idx 2, data 0x0000_00A5, be 0xF, rsp_ready=1 -> one en pulse, addr 0x008, we 0xF at T+1; rsp_valid at T+2, rdata 0.
REQ-034 Then read idx 2 -> en pulse addr 0x008 we 0 at T+1; rsp_valid at T+3 with rdata 0x0000_00A5.
REQ-035 Write idx 3 data 0x1122_3344 be 0x3 over 0xCCCC_CCCC, then read idx 3 -> rdata 0xCCCC_3344.
REQ-036 Read with rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, cmd_ready=0, no en pulses; accepted on 6th.
REQ-037 rst=1 in WAIT state with RD_LAT=3 -> all outputs 0 next cycle, no response; cmd_ready=1 after release.
REQ-038 With REGFILE_MASTER_WRITE_VERIFY_EN, responder bit 0 of idx 4 stuck at 0; write 0xFFFF_FFFF be 0xF -> second en pulse at T+2, rsp_err=1, rdata 0xFFFF_FFFE.
